// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 round controller:
// round constants, controller state encoding and error codes.
package aes_pkg;

    localparam int AES128_NR = 10;
    localparam int AES_RW    = 4;

    typedef enum logic [2:0] {
        IDLE,
        KEYWAIT,
        ISSUE,
        WAIT,
        OUTPUT
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_SPURIOUS = 2'd2
    } err_code_t;

    // States in which a round is in flight and the round flags are meaningful.
    function automatic logic in_round(input ctrl_state_t s);
        return s inside {KEYWAIT, ISSUE, WAIT};
    endfunction

endpackage

// File: rtl/aes_round_wdog.sv
// Clearable watchdog: counts enabled cycles and saturates at TIMEOUT-1,
// where it raises expire until cleared.
module aes_round_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q;

    assign expire = (cnt_q == W'(TIMEOUT - 1));

    // NOTE: sequential state is written with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: walks rounds 0..NR, fetching each round
// key over req/ack and issuing one round at a time to the shared datapath.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR      = AES128_NR,
    parameter int RW      = AES_RW,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          key_req,
    output logic [RW-1:0] key_idx,
    input  logic          key_ack,
    output logic          rnd_valid_out,
    input  logic          rnd_done_in,
    output logic [RW-1:0] round_idx,
    output logic          first_round,
    output logic          last_round,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          err_timeout,
    output logic          err_spurious
);

    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

    ctrl_state_t   state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic          first_q, last_q;
    err_code_t     err_code;
    logic          wdog_expire;

    aes_round_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_q != WAIT),
        .en     (state_q == WAIT),
        .expire (wdog_expire)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        err_code = ERR_NONE;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = KEYWAIT;
                    round_d = '0;
                end
            end
            KEYWAIT: begin
                if (key_ack) state_d = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // Completion wins over a watchdog expiring in the same cycle.
                if (rnd_done_in) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = OUTPUT;
                    end else begin
                        state_d = KEYWAIT;
                        round_d = round_q + RW'(1);
                    end
                end else if (wdog_expire) begin
                    state_d  = IDLE;
                    round_d  = '0;
                    err_code = ERR_TIMEOUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase
        if (rnd_done_in && state_q != WAIT) err_code = ERR_SPURIOUS;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            first_q <= in_round(state_d) && (round_d == '0);
            last_q  <= in_round(state_d) && (round_d == LAST_ROUND);
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign key_req       = (state_q == KEYWAIT);
    assign rnd_valid_out = (state_q == ISSUE);
    assign out_valid     = (state_q == OUTPUT);
    assign round_idx     = round_q;
    assign key_idx       = round_q;
    assign first_round   = first_q;
    assign last_round    = last_q;
    assign err_timeout   = (err_code == ERR_TIMEOUT);
    // Gated so that every output except in_ready reads 0 while reset is held.
    assign err_spurious  = (err_code == ERR_SPURIOUS) && !reset;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: table of block scenarios run through an
// in-bench key/datapath responder, plus hand sequences for reset and idle events.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int NR = AES128_NR;
    localparam int RW = AES_RW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          key_ack = 1'b0;
    logic          rnd_done_in = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, key_req, rnd_valid_out, first_round, last_round;
    logic          out_valid, busy, err_timeout, err_spurious;
    logic [RW-1:0] key_idx, round_idx;

    aes_round_ctrl #(.NR(NR), .RW(RW), .TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .key_req       (key_req),
        .key_idx       (key_idx),
        .key_ack       (key_ack),
        .rnd_valid_out (rnd_valid_out),
        .rnd_done_in   (rnd_done_in),
        .round_idx     (round_idx),
        .first_round   (first_round),
        .last_round    (last_round),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .err_spurious  (err_spurious)
    );

    always #5 clk = ~clk;

    wire [8:0] flags = {in_ready, busy, key_req, rnd_valid_out, out_valid,
                        first_round, last_round, err_timeout, err_spurious};

    typedef struct {
        string name;
        int    stall_round;
        int    stall_len;
        int    bp_len;
        int    spur_round;
        int    hang_round;
        int    exp_lat;
        int    exp_issues;
        int    exp_tout;
        int    exp_spur;
        int    exp_tdelay;
    } vec_t;

    vec_t vecs[5];
    int   total = 0;
    int   bad = 0;
    int   r_lat, r_issues, r_tout, r_spur, r_seq_bad, r_stall_bad, r_hold_bad, r_tdelay, r_hung;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one block and plays key unit / datapath / consumer until the
    // controller is idle again. in_valid is held high throughout to show it is
    // ignored outside IDLE; it is left high on return.
    task automatic run_block(input vec_t v);
        int n, issue_n, issue_at, stall_cnt, bp_cnt;
        bit prev_issue, prev_stall, prev_bp, spurred, done;
        r_lat = -1; r_tout = 0; r_spur = 0; r_seq_bad = 0; r_stall_bad = 0;
        r_hold_bad = 0; r_tdelay = -1;
        in_valid = 1'b1; key_ack = 1'b1; rnd_done_in = 1'b0; out_ready = 1'b0;
        tick();
        n = 0; issue_n = 0; issue_at = 0; stall_cnt = 0; bp_cnt = 0;
        prev_issue = 0; prev_stall = 0; prev_bp = 0; spurred = 0; done = 0;
        while (!done && n < 400) begin
            if (busy == in_ready) r_seq_bad++;
            if (prev_stall && !(key_req && int'(round_idx) == v.stall_round)) r_stall_bad++;
            if (prev_bp && !out_valid) r_hold_bad++;
            if (out_valid && in_ready) r_hold_bad++;
            if (rnd_valid_out) begin
                if (round_idx != RW'(issue_n) || key_idx != RW'(issue_n) ||
                    first_round != (issue_n == 0) || last_round != (issue_n == NR))
                    r_seq_bad++;
                issue_n++;
                issue_at = n;
            end
            if (out_valid && r_lat < 0) r_lat = n;
            if (in_ready) begin
                done = 1;
            end else begin
                in_valid    = 1'b1;
                key_ack     = 1'b1;
                out_ready   = 1'b0;
                rnd_done_in = prev_issue && (int'(round_idx) != v.hang_round);
                prev_issue  = rnd_valid_out;
                if (key_req && int'(round_idx) == v.spur_round && !spurred) begin
                    rnd_done_in = 1'b1;
                    spurred = 1;
                end
                if (key_req && int'(round_idx) == v.stall_round && stall_cnt < v.stall_len) begin
                    key_ack = 1'b0;
                    stall_cnt++;
                end
                prev_stall = !key_ack;
                prev_bp = 0;
                if (out_valid) begin
                    if (bp_cnt < v.bp_len) begin
                        bp_cnt++;
                        prev_bp = 1;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                #1;
                if (err_spurious) r_spur++;
                if (err_timeout) begin
                    r_tout++;
                    r_tdelay = n - issue_at;
                end
                tick();
                n++;
            end
        end
        r_issues = issue_n;
        r_hung = done ? 0 : 1;
        rnd_done_in = 1'b0; key_ack = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit found, prev;
        //           name       stall  len bp spur hang  lat iss to sp tdly
        vecs[0] = '{"nominal",  -1,    0,  0, -1,  -1,   33, 11, 0, 0, -1};
        vecs[1] = '{"keystall",  4,    5,  0, -1,  -1,   38, 11, 0, 0, -1};
        vecs[2] = '{"backpres", -1,    0,  4, -1,  -1,   33, 11, 0, 0, -1};
        vecs[3] = '{"spurious", -1,    0,  0,  3,  -1,   33, 11, 0, 1, -1};
        vecs[4] = '{"hung",     -1,    0,  0, -1,   2,   -1,  3, 1, 0, 16};

        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", int'(flags), 9'b1_0000_0000);
        check("reset_idx", int'({round_idx, key_idx}), 0);
        @(negedge clk) reset = 1'b0;
        tick();

        // Completion strobe while idle: error pulse only, no state change.
        rnd_done_in = 1'b1;
        #1;
        check("spur_idle_pulse", int'(err_spurious), 1);
        tick();
        rnd_done_in = 1'b0;
        #1;
        check("spur_idle_clear", int'(err_spurious), 0);
        check("spur_idle_state", int'({in_ready, busy, round_idx}), 32'b1_0_0000);

        foreach (vecs[i]) begin
            run_block(vecs[i]);
            check({vecs[i].name, "_bound"}, r_hung, 0);
            check({vecs[i].name, "_lat"}, r_lat, vecs[i].exp_lat);
            check({vecs[i].name, "_issues"}, r_issues, vecs[i].exp_issues);
            check({vecs[i].name, "_tout"}, r_tout, vecs[i].exp_tout);
            check({vecs[i].name, "_spur"}, r_spur, vecs[i].exp_spur);
            check({vecs[i].name, "_tdelay"}, r_tdelay, vecs[i].exp_tdelay);
            check({vecs[i].name, "_seq"}, r_seq_bad, 0);
            check({vecs[i].name, "_stall"}, r_stall_bad, 0);
            check({vecs[i].name, "_hold"}, r_hold_bad, 0);
            // in_valid is still high here: the handshake cycle must not accept.
            check({vecs[i].name, "_idle"}, int'({in_ready, busy, key_req, first_round, last_round}), 5'b10000);
            check({vecs[i].name, "_idx0"}, int'(round_idx), 0);
            in_valid = 1'b0;
        end

        // Reset asserted mid-cycle during WAIT of round 6.
        in_valid = 1'b1; key_ack = 1'b1;
        tick();
        in_valid = 1'b0;
        found = 0; prev = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (rnd_valid_out && round_idx == RW'(6)) begin
                found = 1;
            end else begin
                rnd_done_in = prev;
                prev = rnd_valid_out;
                tick();
            end
        end
        check("midop_reach", int'(found), 1);
        rnd_done_in = 1'b0;
        tick();
        check("midop_wait", int'({busy, rnd_valid_out, key_req, out_valid}), 4'b1000);
        check("midop_idx", int'(round_idx), 6);
        #2 reset = 1'b1;
        #1;
        check("midop_rst_flags", int'(flags), 9'b1_0000_0000);
        check("midop_rst_idx", int'({round_idx, key_idx}), 0);
        @(negedge clk) reset = 1'b0;
        key_ack = 1'b0;
        tick();
        check("midop_post_idle", int'(flags), 9'b1_0000_0000);
        run_block(vecs[0]);
        check("after_rst_bound", r_hung, 0);
        check("after_rst_lat", r_lat, 33);
        check("after_rst_issues", r_issues, 11);
        check("after_rst_seq", r_seq_bad, 0);
        check("after_rst_err", r_tout + r_spur, 0);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
